// File: rtl/haar_feature_evaluator.sv
// Evaluates one Haar cascade stage of two-rectangle features on a captured integral-image window.
// Build option: define HAAR_EVAL_SATURATE_EN to saturate the stage accumulator (default wraps).
module haar_feature_evaluator #(
    parameter int DATA_WIDTH_12   = 12,
    parameter int INTEGRAL_WIDTH  = 3,
    parameter int INTEGRAL_HEIGHT = 3,
    parameter int NUM_FEATURES    = 4,
    parameter int ACC_WIDTH       = 20,
    parameter int IDX_W           = 4
) (
    input  logic                                                    clk_os,
    input  logic                                                    reset_os,
    input  logic [INTEGRAL_WIDTH*INTEGRAL_HEIGHT*DATA_WIDTH_12-1:0] i_integral_image,
    input  logic                                                    i_integral_image_ready,
    input  logic signed [ACC_WIDTH-1:0]                             i_stage_threshold,
    input  logic                                                    cfg_wen,
    input  logic [3:0]                                              cfg_addr,
    input  logic [8*IDX_W+55:0]                                     cfg_data,
    output logic                                                    o_busy,
    output logic                                                    o_valid,
    output logic                                                    o_pass,
    output logic signed [ACC_WIDTH-1:0]                             o_stage_sum,
    output logic                                                    o_drop
);
    localparam int N_ENT  = INTEGRAL_WIDTH * INTEGRAL_HEIGHT;
    localparam int WIN_W  = N_ENT * DATA_WIDTH_12;
    localparam int FEAT_W = 8 * IDX_W + 40;
    localparam int CFG_W  = 8 * IDX_W + 56;
    localparam int CMP_W  = (ACC_WIDTH > 16) ? ACC_WIDTH : 16;

    typedef enum logic [2:0] {IDLE, RECT0, RECT1, VOTE, DONE} state_t;

    state_t                      state;
    logic [3:0]                  f_idx;
    logic [FEAT_W-1:0]           feat_tab [16];
    logic [WIN_W-1:0]            win_p0;
    logic signed [ACC_WIDTH-1:0] thr_p0;
    logic signed [ACC_WIDTH-1:0] prod0_p1;
    logic signed [ACC_WIDTH-1:0] fsum_p2;
    logic signed [ACC_WIDTH-1:0] acc;

    // Feature fields sit in the low FEAT_W bits of cfg_data; the top 16 bits are reserved.
    logic unused_cfg;
    assign unused_cfg = ^cfg_data[CFG_W-1:FEAT_W];

    function automatic logic signed [ACC_WIDTH-1:0] corner(input logic [IDX_W-1:0] idx,
                                                           input logic [WIN_W-1:0] win);
        logic signed [ACC_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < N_ENT; i++)
            if (idx == IDX_W'(i)) v = ACC_WIDTH'(win[i*DATA_WIDTH_12 +: DATA_WIDTH_12]);
        return v;
    endfunction

    // Corner indices packed {a, b, c, d}; area = d - b - c + a.
    function automatic logic signed [ACC_WIDTH-1:0] rect_sum(input logic [4*IDX_W-1:0] idx,
                                                             input logic [WIN_W-1:0] win);
        return corner(idx[IDX_W-1:0], win) - corner(idx[3*IDX_W-1:2*IDX_W], win)
             - corner(idx[2*IDX_W-1:IDX_W], win) + corner(idx[4*IDX_W-1:3*IDX_W], win);
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] acc_add(input logic signed [ACC_WIDTH-1:0] a,
                                                            input logic signed [7:0] v);
`ifdef HAAR_EVAL_SATURATE_EN
        logic signed [ACC_WIDTH:0] s;
        s = (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(v);
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
            return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        return s[ACC_WIDTH-1:0];
`else
        return a + ACC_WIDTH'(v);
`endif
    endfunction

    logic [FEAT_W-1:0]           feat;
    logic [4*IDX_W-1:0]          r0_idx, r1_idx;
    logic signed [3:0]           w0, w1;
    logic signed [15:0]          f_thr;
    logic signed [7:0]           vote_pass, vote_fail, vote;
    logic signed [ACC_WIDTH-1:0] rect0, rect1, prod0, fsum, acc_next;
    logic                        capture, last_feat, cfg_ok;

    assign feat      = feat_tab[f_idx];
    assign r0_idx    = feat[FEAT_W-1 -: 4*IDX_W];
    assign r1_idx    = feat[FEAT_W-1-4*IDX_W -: 4*IDX_W];
    assign w0        = feat[39:36];
    assign w1        = feat[35:32];
    assign f_thr     = feat[31:16];
    assign vote_pass = feat[15:8];
    assign vote_fail = feat[7:0];

    assign rect0    = rect_sum(r0_idx, win_p0);
    assign rect1    = rect_sum(r1_idx, win_p0);
    assign prod0    = ACC_WIDTH'(w0) * rect0;
    assign fsum     = prod0_p1 + ACC_WIDTH'(w1) * rect1;
    assign vote     = (CMP_W'(fsum_p2) < CMP_W'(f_thr)) ? vote_fail : vote_pass;
    assign acc_next = acc_add(acc, vote);

    assign capture   = (state == IDLE) && i_integral_image_ready;
    assign last_feat = (f_idx == 4'(NUM_FEATURES - 1));
    assign cfg_ok    = cfg_wen && ({1'b0, cfg_addr} < 5'(NUM_FEATURES));

    always_ff @(posedge clk_os or negedge reset_os) begin
        if (!reset_os) begin
            state       <= IDLE;
            f_idx       <= '0;
            acc         <= '0;
            o_busy      <= 1'b0;
            o_valid     <= 1'b0;
            o_pass      <= 1'b0;
            o_stage_sum <= '0;
            o_drop      <= 1'b0;
            for (int i = 0; i < 16; i++) feat_tab[i] <= '0;
        end else begin
            if (i_integral_image_ready && state != IDLE) o_drop <= 1'b1;
            case (state)
                IDLE: begin
                    if (capture) begin
                        acc    <= '0;
                        f_idx  <= '0;
                        o_busy <= 1'b1;
                        state  <= RECT0;
                    end else if (cfg_ok) begin
                        feat_tab[cfg_addr] <= cfg_data[FEAT_W-1:0];
                    end
                end
                RECT0: state <= RECT1;
                RECT1: state <= VOTE;
                VOTE: begin
                    acc <= acc_next;
                    if (last_feat) begin
                        o_valid     <= 1'b1;
                        o_pass      <= (acc_next >= thr_p0);
                        o_stage_sum <= acc_next;
                        state       <= DONE;
                    end else begin
                        f_idx <= f_idx + 4'd1;
                        state <= RECT0;
                    end
                end
                DONE: begin
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // p0: window capture, p1: weighted rect0, p2: feature sum
    always_ff @(posedge clk_os) begin
        if (capture) begin
            win_p0 <= i_integral_image;
            thr_p0 <= i_stage_threshold;
        end
        if (state == RECT0) prod0_p1 <= prod0;
        if (state == RECT1) fsum_p2 <= fsum;
    end
endmodule

// File: tb/tb_haar_feature_evaluator.sv
// Bench for haar_feature_evaluator: directed stage tests plus random traffic checked against a stage model.
`timescale 1ns/1ps
module tb_haar_feature_evaluator;
    localparam int D = 12, W = 3, H = 3, N = 4, ACC = 20, IDX = 4;
    localparam int NE = W * H, CFG_W = 8 * IDX + 56;

    logic clk_os = 1'b0;
    logic reset_os = 1'b1;
    always #5 clk_os = ~clk_os;

    logic [NE*D-1:0]       i_integral_image = '0;
    logic                  ready = 1'b0;
    logic signed [ACC-1:0] sthr = '0;
    logic                  cfg_wen = 1'b0;
    logic [3:0]            cfg_addr = '0;
    logic [CFG_W-1:0]      cfg_data = '0;
    logic                  o_busy, o_valid, o_pass, o_drop;
    logic signed [ACC-1:0] o_stage_sum;

    logic                  ready8 = 1'b0;
    logic signed [7:0]     sthr8 = '0;
    logic                  cfg_wen8 = 1'b0;
    logic [3:0]            cfg_addr8 = '0;
    logic [CFG_W-1:0]      cfg_data8 = '0;
    logic                  o_busy8, o_valid8, o_pass8, o_drop8;
    logic signed [7:0]     o_stage_sum8;

    haar_feature_evaluator #(.DATA_WIDTH_12(D), .INTEGRAL_WIDTH(W), .INTEGRAL_HEIGHT(H),
        .NUM_FEATURES(N), .ACC_WIDTH(ACC), .IDX_W(IDX)) dut (
        .clk_os(clk_os), .reset_os(reset_os), .i_integral_image(i_integral_image),
        .i_integral_image_ready(ready), .i_stage_threshold(sthr), .cfg_wen(cfg_wen),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .o_busy(o_busy), .o_valid(o_valid),
        .o_pass(o_pass), .o_stage_sum(o_stage_sum), .o_drop(o_drop));

    haar_feature_evaluator #(.DATA_WIDTH_12(D), .INTEGRAL_WIDTH(W), .INTEGRAL_HEIGHT(H),
        .NUM_FEATURES(N), .ACC_WIDTH(8), .IDX_W(IDX)) dut8 (
        .clk_os(clk_os), .reset_os(reset_os), .i_integral_image(i_integral_image),
        .i_integral_image_ready(ready8), .i_stage_threshold(sthr8), .cfg_wen(cfg_wen8),
        .cfg_addr(cfg_addr8), .cfg_data(cfg_data8), .o_busy(o_busy8), .o_valid(o_valid8),
        .o_pass(o_pass8), .o_stage_sum(o_stage_sum8), .o_drop(o_drop8));

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus-side feature fields; corner order is a, b, c, d.
    int win_v [NE];
    int cur_r0 [4];
    int cur_r1 [4];
    int cur_w0, cur_w1, cur_thr, cur_vp, cur_vf;

    function automatic logic [CFG_W-1:0] pack_cur();
        return {16'b0, IDX'(cur_r0[0]), IDX'(cur_r0[1]), IDX'(cur_r0[2]), IDX'(cur_r0[3]),
                IDX'(cur_r1[0]), IDX'(cur_r1[1]), IDX'(cur_r1[2]), IDX'(cur_r1[3]),
                4'(cur_w0), 4'(cur_w1), 16'(cur_thr), 8'(cur_vp), 8'(cur_vf)};
    endfunction

    task automatic clear_cur();
        for (int i = 0; i < 4; i++) begin cur_r0[i] = 0; cur_r1[i] = 0; end
        cur_w0 = 0; cur_w1 = 0; cur_thr = 0; cur_vp = 0; cur_vf = 0;
    endtask

    task automatic load_image();
        for (int i = 0; i < NE; i++) i_integral_image[i*D +: D] = D'(win_v[i]);
    endtask

    // Reference model: table contents and a stage result computed with plain integer arithmetic.
    int     m_r0 [N][4];
    int     m_r1 [N][4];
    int     m_w0 [N], m_w1 [N], m_thr [N], m_vp [N], m_vf [N];
    int     m_cnt = 0;
    bit     m_drop = 0, m_pass = 0, res_pass = 0;
    longint m_sum = 0, res_sum = 0;

    function automatic longint wrapn(input longint x, input int w);
        longint half, m;
        half = longint'(1) << (w - 1);
        m = x & ((half << 1) - 1);
        if (m >= half) m = m - (half << 1);
        return m;
    endfunction

    function automatic longint ent(input int i);
        return (i < NE) ? longint'(win_v[i]) : 0;
    endfunction

    function automatic longint model_eval();
        longint acc, r0, r1, fs, vote, lim;
        acc = 0;
        lim = longint'(1) << (ACC - 1);
        for (int f = 0; f < N; f++) begin
            r0 = wrapn(ent(m_r0[f][3]) - ent(m_r0[f][1]) - ent(m_r0[f][2]) + ent(m_r0[f][0]), ACC);
            r1 = wrapn(ent(m_r1[f][3]) - ent(m_r1[f][1]) - ent(m_r1[f][2]) + ent(m_r1[f][0]), ACC);
            fs = wrapn(wrapn(m_w0[f] * r0, ACC) + m_w1[f] * r1, ACC);
            vote = (fs < m_thr[f]) ? m_vf[f] : m_vp[f];
`ifdef HAAR_EVAL_SATURATE_EN
            acc = acc + vote;
            if (acc > lim - 1) acc = lim - 1;
            if (acc < -lim) acc = -lim;
`else
            acc = wrapn(acc + vote, ACC);
`endif
        end
        return acc;
    endfunction

    always @(posedge clk_os or negedge reset_os) begin
        if (!reset_os) begin
            m_cnt  <= 0;
            m_drop <= 0;
            m_sum  <= 0;
            m_pass <= 0;
            for (int f = 0; f < N; f++) begin
                for (int j = 0; j < 4; j++) begin m_r0[f][j] <= 0; m_r1[f][j] <= 0; end
                m_w0[f] <= 0; m_w1[f] <= 0; m_thr[f] <= 0; m_vp[f] <= 0; m_vf[f] <= 0;
            end
        end else if (m_cnt == 0) begin
            if (ready) begin
                res_sum  <= model_eval();
                res_pass <= (model_eval() >= longint'(sthr));
                m_cnt    <= 1 + 3 * N;
            end else if (cfg_wen && cfg_addr < N) begin
                for (int j = 0; j < 4; j++) begin
                    m_r0[cfg_addr][j] <= cur_r0[j];
                    m_r1[cfg_addr][j] <= cur_r1[j];
                end
                m_w0[cfg_addr] <= cur_w0; m_w1[cfg_addr] <= cur_w1; m_thr[cfg_addr] <= cur_thr;
                m_vp[cfg_addr] <= cur_vp; m_vf[cfg_addr] <= cur_vf;
            end
        end else begin
            if (ready) m_drop <= 1;
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) begin
                m_sum  <= res_sum;
                m_pass <= res_pass;
            end
        end
    end

    always @(negedge clk_os) begin
        check("busy", longint'(o_busy), longint'(m_cnt != 0));
        check("valid", longint'(o_valid), longint'(m_cnt == 1));
        check("drop", longint'(o_drop), longint'(m_drop));
        check("pass", longint'(o_pass), longint'(m_pass));
        check("stage_sum", longint'(o_stage_sum), m_sum);
    end

    task automatic write_cfg(input int addr);
        @(posedge clk_os); #2;
        cfg_addr = 4'(addr); cfg_data = pack_cur(); cfg_wen = 1'b1;
        @(posedge clk_os); #2;
        cfg_wen = 1'b0;
    endtask

    task automatic write_cfg8(input int addr);
        @(posedge clk_os); #2;
        cfg_addr8 = 4'(addr); cfg_data8 = pack_cur(); cfg_wen8 = 1'b1;
        @(posedge clk_os); #2;
        cfg_wen8 = 1'b0;
    endtask

    // Pulses ready, then waits for o_valid; lat counts cycles after the capture edge (1 = next cycle).
    task automatic run_window(input int drop_at, input int wcfg_at, output int lat);
        load_image();
        @(posedge clk_os); #2;
        ready = 1'b1;
        @(posedge clk_os); #2;
        ready = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk_os);
            if (o_valid) begin lat = n; break; end
            ready   = (n == drop_at);
            cfg_wen = (n == wcfg_at);
        end
        ready = 1'b0;
        cfg_wen = 1'b0;
        if (lat == 0) check("valid_timeout", 0, 1);
    endtask

    task automatic base_window();
        int v [NE] = '{1, 2, 3, 2, 4, 6, 3, 6, 9};
        for (int i = 0; i < NE; i++) win_v[i] = v[i];
    endtask

    task automatic base_feature(input int thr);
        clear_cur();
        cur_r0[0] = 0; cur_r0[1] = 2; cur_r0[2] = 6; cur_r0[3] = 8;
        cur_w0 = 1; cur_thr = thr; cur_vp = 10; cur_vf = -10;
    endtask

    initial begin
        int lat;
        #1 reset_os = 1'b0;
        repeat (3) @(posedge clk_os);
        #1;
        check("rst_busy", longint'(o_busy), 0);
        check("rst_valid", longint'(o_valid), 0);
        check("rst_sum", longint'(o_stage_sum), 0);
        check("rst_drop", longint'(o_drop), 0);
        @(negedge clk_os); reset_os = 1'b1;

        base_window();
        base_feature(4);
        write_cfg(0);
        sthr = 10;
        run_window(0, 0, lat);
        check("t1_latency", lat, 13);
        check("t1_sum", longint'(o_stage_sum), 10);
        check("t1_pass", longint'(o_pass), 1);

        run_window(5, 0, lat);
        check("drop_latency", lat, 13);
        check("drop_sum", longint'(o_stage_sum), 10);
        check("drop_flag", longint'(o_drop), 1);

        base_feature(5);
        cfg_addr = 4'd0; cfg_data = pack_cur();
        run_window(0, 3, lat);
        check("busy_wr_sum", longint'(o_stage_sum), 10);
        run_window(0, 0, lat);
        check("old_table_sum", longint'(o_stage_sum), 10);
        write_cfg(7);
        run_window(0, 0, lat);
        check("addr7_sum", longint'(o_stage_sum), 10);
        write_cfg(0);
        run_window(0, 0, lat);
        check("t2_sum", longint'(o_stage_sum), -10);
        check("t2_pass", longint'(o_pass), 0);

        load_image();
        @(posedge clk_os); #2; ready = 1'b1;
        @(posedge clk_os); #2; ready = 1'b0;
        repeat (5) @(posedge clk_os);
        #3 reset_os = 1'b0;
        #1;
        check("arst_busy", longint'(o_busy), 0);
        check("arst_valid", longint'(o_valid), 0);
        check("arst_drop", longint'(o_drop), 0);
        check("arst_sum", longint'(o_stage_sum), 0);
        check("arst_pass", longint'(o_pass), 0);
        @(negedge clk_os); @(negedge clk_os); reset_os = 1'b1;
        sthr = 0;
        run_window(0, 0, lat);
        check("fresh_latency", lat, 13);
        check("fresh_sum", longint'(o_stage_sum), 0);
        check("fresh_pass", longint'(o_pass), 1);
        base_feature(4);
        write_cfg(0);
        sthr = 10;
        run_window(0, 0, lat);
        check("reprog_sum", longint'(o_stage_sum), 10);

        clear_cur();
        cur_vp = 127;
        for (int a = 0; a < N; a++) write_cfg8(a);
        @(posedge clk_os); #2; ready8 = 1'b1;
        @(posedge clk_os); #2; ready8 = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk_os);
            if (o_valid8) begin lat = n; break; end
        end
        check("acc8_latency", lat, 13);
`ifdef HAAR_EVAL_SATURATE_EN
        check("acc8_sum", longint'(o_stage_sum8), 127);
        check("acc8_pass", longint'(o_pass8), 1);
`else
        check("acc8_sum", longint'(o_stage_sum8), -4);
        check("acc8_pass", longint'(o_pass8), 0);
`endif
        check("acc8_busy", longint'(o_busy8), 1);
        check("acc8_drop", longint'(o_drop8), 0);

        for (int c = 0; c < 2500; c++) begin
            int r;
            @(posedge clk_os); #2;
            ready = 1'b0;
            cfg_wen = 1'b0;
            r = $urandom_range(0, 19);
            if (r < 3) begin
                for (int j = 0; j < 4; j++) begin
                    cur_r0[j] = $urandom_range(0, 10);
                    cur_r1[j] = $urandom_range(0, 10);
                end
                cur_w0 = int'($urandom_range(0, 15)) - 8;
                cur_w1 = int'($urandom_range(0, 15)) - 8;
                cur_thr = int'($urandom_range(0, 4000)) - 2000;
                cur_vp = int'($urandom_range(0, 255)) - 128;
                cur_vf = int'($urandom_range(0, 255)) - 128;
                cfg_addr = 4'($urandom_range(0, 5));
                cfg_data = pack_cur();
                cfg_wen = 1'b1;
            end else if (r < 5) begin
                for (int i = 0; i < NE; i++) win_v[i] = $urandom_range(0, 4095);
                load_image();
                sthr = ACC'(int'($urandom_range(0, 400)) - 200);
                ready = 1'b1;
            end
        end
        @(posedge clk_os); #2;
        ready = 1'b0;
        cfg_wen = 1'b0;
        repeat (20) @(posedge clk_os);
        @(negedge clk_os); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/haar_feature_evaluator.md
# haar_feature_evaluator

Consumes the integral-image window produced by the integral line-buffer stage and evaluates one Haar cascade stage on it. On each window-ready pulse it captures the window, steps through a configurable table of two-rectangle features, accumulates signed votes, and reports a single pass/fail decision per window. It sits directly downstream of the integral window builder and upstream of cascade control.

## Interface
- DATA_WIDTH_12, 12: width of one integral-image entry (unsigned).
- INTEGRAL_WIDTH, 3: window width in entries.
- INTEGRAL_HEIGHT, 3: window height in entries.
- NUM_FEATURES, 4: feature-table depth, 1..16.
- ACC_WIDTH, 20: signed width of rectangle, feature and stage sums.
- IDX_W, 4: corner index width, ≥ clog2(INTEGRAL_WIDTH*INTEGRAL_HEIGHT).

Ports:
- clk_os  in  1  sole clock, rising edge.
- reset_os  in  1  asynchronous, active-low reset.
- i_integral_image  in  INTEGRAL_WIDTH*INTEGRAL_HEIGHT*DATA_WIDTH_12  flat window; entry i = x+INTEGRAL_WIDTH*y at bits [i*DATA_WIDTH_12 +: DATA_WIDTH_12].
- i_integral_image_ready  in  1  window valid this cycle (pulse).
- i_stage_threshold  in  ACC_WIDTH  signed stage threshold, sampled at capture.
- cfg_wen  in  1  feature-table write strobe.
- cfg_addr  in  4  feature index.
- cfg_data  in  8*IDX_W+56  {r0_a,r0_b,r0_c,r0_d, r1_a,r1_b,r1_c,r1_d (IDX_W each), w0[3:0], w1[3:0] signed, thr[15:0] signed, vote_pass[7:0] signed, vote_fail[7:0] signed}, MSB first.
- o_busy  out  1  evaluation in progress.
- o_valid  out  1  one-cycle result strobe.
- o_pass  out  1  stage decision, valid with o_valid.
- o_stage_sum  out  ACC_WIDTH  final signed vote sum, held until next result.
- o_drop  out  1  sticky: a window arrived while busy.

## Operation
- FSM states: IDLE, RECT0, RECT1, VOTE, DONE.
- IDLE: on i_integral_image_ready, register whole window and i_stage_threshold, clear stage accumulator and feature index f=0, go RECT0.
- RECT0: rect0 = d − b − c + a using entries r0_a..r0_d of feature f (a top-left, b top-right, c bottom-left, d bottom-right), zero-extended to ACC_WIDTH; register w0*rect0. → RECT1.
- RECT1: same for rectangle 1; register feature_sum = w0*rect0 + w1*rect1 (ACC_WIDTH, two's-complement wrap). → VOTE.
- VOTE: if feature_sum < sign-extended thr (signed compare) add vote_fail to accumulator, else add vote_pass. If f = NUM_FEATURES−1 → DONE, else f+1 → RECT0.
- DONE: o_valid=1, o_pass = (accumulator ≥ i_stage_threshold latched, signed), o_stage_sum = accumulator; → IDLE.
- Corner index ≥ INTEGRAL_WIDTH*INTEGRAL_HEIGHT reads as 0.
- Feature table: cfg_wen writes cfg_data to entry cfg_addr when state is IDLE and cfg_addr < NUM_FEATURES; otherwise write ignored. Write and window capture in the same IDLE cycle: write lands first is NOT required — evaluation uses the table as it was before that edge.
- i_integral_image_ready while not IDLE (including DONE): window dropped, o_drop set; cleared only by reset.

## Timing
- Reset (async assert): state IDLE, all outputs 0, accumulator 0, feature table all-zero (every feature votes vote_pass=0).
- Reset mid-evaluation aborts immediately; no o_valid produced.
- Capture edge k: o_busy high from k+1 through DONE cycle; o_valid high exactly in cycle k+1+3*NUM_FEATURES (default 13).
- Next window accepted in the cycle after DONE (IDLE); minimum window spacing 2+3*NUM_FEATURES cycles.
- o_pass/o_stage_sum registered, stable until next DONE.

## Configuration
- HAAR_EVAL_SATURATE_EN defined: stage accumulator saturates at signed ACC_WIDTH min/max on each VOTE add.
- Undefined: accumulator wraps (two's complement). Feature_sum wraps in both builds.

## Test plan
- All-ones image window {1,2,3,2,4,6,3,6,9}; feature 0 r0=(0,2,6,8) w0=1, r1 indices 0 w1=0, thr=4, pass=+10, fail=−10; others zero; stage threshold 10 -> o_valid at k+13, o_stage_sum=10, o_pass=1.
- Same, thr=5 -> rect sum 4 < 5, o_stage_sum=−10, o_pass=0.
- Ready pulse at k+5 during evaluation -> ignored, o_drop=1, single o_valid at k+13 with unchanged result.
- cfg_wen during busy with new thr -> ignored; next window uses old table; cfg_addr=7 with NUM_FEATURES=4 -> no effect.
- reset_os low at k+6 -> all outputs 0 immediately, no o_valid; fresh window after release evaluates normally.
- Four features each vote +127, ACC_WIDTH=8: with HAAR_EVAL_SATURATE_EN o_stage_sum=127; without, wrapped value 508 mod 256 = −4.
